// File: rtl/hermes_pkg.sv
// -----------------------------------------------------------------------------
// hermes_pkg
// Shared definitions for the Hermes local-port packet injector.
//  - default flit / size-field widths
//  - router port indices (EAST..LOCAL)
//  - inject FSM state encoding
//  - header field layout and header builder
// -----------------------------------------------------------------------------
package hermes_pkg;

   localparam int FLIT_WIDTH_DEF = 32;
   localparam int SIZE_WIDTH_DEF = 16;

   // Router port indices
   localparam logic [2:0] PORT_EAST  = 3'd0;
   localparam logic [2:0] PORT_WEST  = 3'd1;
   localparam logic [2:0] PORT_NORTH = 3'd2;
   localparam logic [2:0] PORT_SOUTH = 3'd3;
   localparam logic [2:0] PORT_LOCAL = 3'd4;

   // Header layout: bits [15:0] = {YY, XX}
   localparam int HDR_WIDTH = 16;
   localparam int HDR_X_LSB = 0;
   localparam int HDR_Y_LSB = 8;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_HEADER  = 2'd1,
      S_SIZE    = 2'd2,
      S_PAYLOAD = 2'd3
   } inject_state_t;

   function automatic logic [HDR_WIDTH-1:0] make_header(input logic [7:0] x,
                                                       input logic [7:0] y);
      return {y, x};
   endfunction

endpackage

// File: rtl/hermes_pkt_inject_stage.sv
// -----------------------------------------------------------------------------
// hermes_flit_stage
// One-entry payload staging register. Accepts a flit when allowed and either
// empty or being emptied this cycle; holds its contents until popped, so the
// flit presented downstream never changes while the router withholds credit.
// Ports:
//  clock, reset   clock / synchronous active-high reset (clears entry)
//  load_en        upstream may be accepted this cycle
//  in_valid/in_data/in_ready   upstream handshake
//  pop            staged flit transferred this cycle
//  out_valid/out_data          staged flit
// -----------------------------------------------------------------------------
module hermes_flit_stage #(
   parameter int FLIT_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  load_en,
   input  logic                  in_valid,
   input  logic [FLIT_WIDTH-1:0] in_data,
   output logic                  in_ready,
   input  logic                  pop,
   output logic                  out_valid,
   output logic [FLIT_WIDTH-1:0] out_data
);

   logic                  vld_r;
   logic [FLIT_WIDTH-1:0] data_r;
   logic                  load_s;

   // Refill is allowed in the same cycle the current entry leaves.
   assign in_ready  = load_en && (!vld_r || pop);
   assign load_s    = in_valid && in_ready;
   assign out_valid = vld_r;
   assign out_data  = data_r;

   // Staging entry: load, drain or hold.
   always_ff @(posedge clock) begin
      if (reset) begin
         vld_r  <= 1'b0;
         data_r <= '0;
      end else if (load_s) begin
         vld_r  <= 1'b1;
         data_r <= in_data;
      end else if (pop) begin
         vld_r  <= 1'b0;
      end
   end

endmodule

// File: rtl/hermes_pkt_inject.sv
// -----------------------------------------------------------------------------
// hermes_pkt_inject
// Local-port packet transmitter for a Hermes router input. Takes a request
// (target XY, payload length) plus a payload stream and emits header, size and
// payload flits under credit flow control (tx = flit valid && credit_i).
// Ports:
//  clock, reset                synchronous active-high reset
//  req_valid/req_ready         request handshake; req_x, req_y, req_size
//  pl_valid/pl_data/pl_ready   payload stream handshake
//  clock_tx, tx, data_out      router-side flit interface
//  credit_i                    router buffer space available this cycle
//  busy                        packet in progress
//  pkt_done                    pulse with the last flit's transfer
// -----------------------------------------------------------------------------
module hermes_pkt_inject
   import hermes_pkg::*;
#(
   parameter int FLIT_WIDTH = FLIT_WIDTH_DEF,
   parameter int SIZE_WIDTH = SIZE_WIDTH_DEF
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [7:0]            req_x,
   input  logic [7:0]            req_y,
   input  logic [SIZE_WIDTH-1:0] req_size,
   input  logic                  pl_valid,
   input  logic [FLIT_WIDTH-1:0] pl_data,
   output logic                  pl_ready,
   output logic                  clock_tx,
   output logic                  tx,
   output logic [FLIT_WIDTH-1:0] data_out,
   input  logic                  credit_i,
   output logic                  busy,
   output logic                  pkt_done
);

   inject_state_t          state_r, state_s;
   logic [HDR_WIDTH-1:0]   hdr_r;
   logic [SIZE_WIDTH-1:0]  size_r;
   logic [SIZE_WIDTH-1:0]  remaining_r;   // payload flits still to transmit
   logic [SIZE_WIDTH-1:0]  to_stage_r;    // payload flits still to accept
   logic                   req_fire_s;
   logic                   flit_vld_s;
   logic                   stg_load_en_s;
   logic                   stg_pop_s;
   logic                   stg_vld_s;
   logic [FLIT_WIDTH-1:0]  stg_data_s;
   logic                   pl_fire_s;

   assign clock_tx   = clock;
   assign req_ready  = (state_r == S_IDLE);
   assign busy       = (state_r != S_IDLE);
   assign req_fire_s = req_valid && req_ready;
   // Reset suppresses transfers in the very cycle it is sampled.
   assign tx         = flit_vld_s && credit_i && !reset;
   assign stg_pop_s  = tx && (state_r == S_PAYLOAD);
   assign pl_fire_s  = pl_valid && pl_ready;
   // Payload is prefetched during header/size so it can follow without a bubble.
   assign stg_load_en_s = !reset && (state_r != S_IDLE) && (to_stage_r != '0);

   hermes_flit_stage #(.FLIT_WIDTH(FLIT_WIDTH)) u_stage (
      .clock     (clock),
      .reset     (reset),
      .load_en   (stg_load_en_s),
      .in_valid  (pl_valid),
      .in_data   (pl_data),
      .in_ready  (pl_ready),
      .pop       (stg_pop_s),
      .out_valid (stg_vld_s),
      .out_data  (stg_data_s)
   );

   // FSM state register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Request fields and flit counters.
   always_ff @(posedge clock) begin
      if (reset) begin
         hdr_r       <= '0;
         size_r      <= '0;
         remaining_r <= '0;
         to_stage_r  <= '0;
      end else if (req_fire_s) begin
         hdr_r       <= make_header(req_x, req_y);
         size_r      <= req_size;
         remaining_r <= req_size;
         to_stage_r  <= req_size;
      end else begin
         if (stg_pop_s) begin
            remaining_r <= remaining_r - SIZE_WIDTH'(1);
         end
         if (pl_fire_s) begin
            to_stage_r <= to_stage_r - SIZE_WIDTH'(1);
         end
      end
   end

   // Next state, flit-valid, data mux and completion pulse.
   always_comb begin
      state_s    = state_r;
      flit_vld_s = 1'b0;
      data_out   = '0;
      pkt_done   = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (req_fire_s) begin
               state_s = S_HEADER;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_HEADER: begin
            flit_vld_s = 1'b1;
            data_out   = {{(FLIT_WIDTH-HDR_WIDTH){1'b0}}, hdr_r};
            if (tx) begin
               state_s = S_SIZE;
            end else begin
               state_s = S_HEADER;
            end
         end
         S_SIZE: begin
            flit_vld_s = 1'b1;
            data_out   = {{(FLIT_WIDTH-SIZE_WIDTH){1'b0}}, size_r};
            if (tx && (size_r == '0)) begin
               pkt_done = 1'b1;
               state_s  = S_IDLE;
            end else if (tx) begin
               state_s  = S_PAYLOAD;
            end else begin
               state_s  = S_SIZE;
            end
         end
         S_PAYLOAD: begin
            flit_vld_s = stg_vld_s;
            data_out   = stg_data_s;
            if (tx && (remaining_r == SIZE_WIDTH'(1))) begin
               pkt_done = 1'b1;
               state_s  = S_IDLE;
            end else begin
               state_s  = S_PAYLOAD;
            end
         end
         default: begin
            state_s = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_hermes_pkt_inject.sv
// -----------------------------------------------------------------------------
// tb_hermes_pkt_inject
// Bench for hermes_pkt_inject: stimulus pushes each packet's expected flit
// sequence into a queue; an independent monitor pops and compares whenever
// tx is high.
// -----------------------------------------------------------------------------
module tb_hermes_pkt_inject;

   localparam int FW = 32;
   localparam int SW = 16;

   logic          clock = 1'b0;
   logic          reset;
   logic          req_valid;
   logic          req_ready;
   logic [7:0]    req_x;
   logic [7:0]    req_y;
   logic [SW-1:0] req_size;
   logic          pl_valid;
   logic [FW-1:0] pl_data;
   logic          pl_ready;
   logic          clock_tx;
   logic          tx;
   logic [FW-1:0] data_out;
   logic          credit_i;
   logic          busy;
   logic          pkt_done;

   typedef struct {
      logic [FW-1:0] data;
      bit            last;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   bit   mon_en = 1'b0;

   always #5 clock = ~clock;

   hermes_pkt_inject #(.FLIT_WIDTH(FW), .SIZE_WIDTH(SW)) dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_x     (req_x),
      .req_y     (req_y),
      .req_size  (req_size),
      .pl_valid  (pl_valid),
      .pl_data   (pl_data),
      .pl_ready  (pl_ready),
      .clock_tx  (clock_tx),
      .tx        (tx),
      .data_out  (data_out),
      .credit_i  (credit_i),
      .busy      (busy),
      .pkt_done  (pkt_done)
   );

   task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every transferred flit must match the head of the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (mon_en) begin
            check("req_ready_idle", {31'd0, req_ready}, {31'd0, !busy});
            if (tx === 1'b1) begin
               check("tx_needs_credit", {31'd0, credit_i}, 32'd1);
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_flit: got %h want none", data_out);
               end else begin
                  e = exp_q.pop_front();
                  check("flit_data", data_out, e.data);
                  check("pkt_done_flag", {31'd0, pkt_done}, {31'd0, e.last});
               end
            end else if (pkt_done !== 1'b0) begin
               total++;
               bad++;
               $display("FAIL pkt_done_without_tx: got %b want 0", pkt_done);
            end
         end
      end
   end

   // Run one packet: expected flits are derived from the request itself.
   task automatic run_packet(input logic [7:0] x, input logic [7:0] y, input int size,
                             input int credit_pct, input int plv_pct,
                             input int stall_flit, input int stall_len,
                             input int gap_after, input int gap_len,
                             input int abort_after, input bit tight);
      logic [FW-1:0] pl[$];
      logic [FW-1:0] flits[$];
      exp_t          e;
      int idx = 0, txc = 0, cyc = 0, acc_cyc = -1;
      int stall_left = stall_len, gap_left = gap_len;
      int max_cyc = 200 + size * 20;
      bit finished = 1'b0, stalling = 1'b0, req_fire, pl_fire, done_now;

      for (int i = 0; i < size; i++) pl.push_back($urandom());
      flits.push_back({16'h0, y, x});
      flits.push_back(FW'(size));
      for (int i = 0; i < size; i++) flits.push_back(pl[i]);
      for (int i = 0; i < flits.size(); i++) begin
         e.data = flits[i];
         e.last = (i == flits.size() - 1);
         exp_q.push_back(e);
      end

      req_x     = x;
      req_y     = y;
      req_size  = SW'(size);
      req_valid = 1'b1;
      pl_valid  = (size > 0);
      pl_data   = (size > 0) ? pl[0] : '0;
      credit_i  = ($urandom_range(0, 99) < credit_pct);

      while (!finished && cyc < max_cyc) begin
         @(negedge clock);
         cyc++;
         req_fire = req_valid && req_ready;
         pl_fire  = pl_valid && pl_ready;
         done_now = pkt_done;
         if (tx) txc++;
         if (stalling) begin
            check("stall_no_tx", {31'd0, tx}, 32'd0);
            check("stall_data_hold", data_out, flits[stall_flit]);
         end
         if (idx >= size) check("pl_ready_after_last", {31'd0, pl_ready}, 32'd0);
         if (req_fire) acc_cyc = cyc;
         if (done_now) begin
            finished = 1'b1;
            check("tx_count", txc, size + 2);
            if (tight) check("packet_latency", cyc - acc_cyc, size + 2);
         end

         @(posedge clock);
         #1;
         if (req_fire) req_valid = 1'b0;
         if (pl_fire) idx++;

         if (!finished && abort_after >= 0 && txc >= abort_after) begin
            reset     = 1'b1;
            req_valid = 1'b0;
            pl_valid  = 1'b0;
            credit_i  = 1'b1;
            @(negedge clock);
            check("abort_tx_low", {31'd0, tx}, 32'd0);
            check("abort_no_done", {31'd0, pkt_done}, 32'd0);
            @(posedge clock);
            #1;
            reset = 1'b0;
            exp_q.delete();
            @(negedge clock);
            check("abort_idle", {31'd0, busy}, 32'd0);
            check("abort_req_ready", {31'd0, req_ready}, 32'd1);
            check("abort_pl_ready", {31'd0, pl_ready}, 32'd0);
            check("abort_done_low", {31'd0, pkt_done}, 32'd0);
            @(posedge clock);
            #1;
            return;
         end

         stalling = 1'b0;
         if (stall_flit >= 0 && txc == stall_flit && stall_left > 0) begin
            credit_i = 1'b0;
            stall_left--;
            stalling = 1'b1;
         end else begin
            credit_i = ($urandom_range(0, 99) < credit_pct);
         end

         if (idx < size) begin
            if (gap_after >= 0 && idx == gap_after && gap_left > 0) begin
               pl_valid = 1'b0;
               gap_left--;
            end else begin
               pl_valid = ($urandom_range(0, 99) < plv_pct);
            end
            pl_data = pl[idx];
         end else begin
            pl_valid = 1'b0;
            pl_data  = '0;
         end
      end

      if (!finished) begin
         total++;
         bad++;
         $display("FAIL packet_timeout: got no pkt_done want pkt_done within %0d cycles", max_cyc);
      end
      req_valid = 1'b0;
      pl_valid  = 1'b0;
   endtask

   initial begin
      reset     = 1'b1;
      req_valid = 1'b0;
      req_x     = '0;
      req_y     = '0;
      req_size  = '0;
      pl_valid  = 1'b0;
      pl_data   = '0;
      credit_i  = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      check("rst_req_ready", {31'd0, req_ready}, 32'd1);
      check("rst_pl_ready", {31'd0, pl_ready}, 32'd0);
      check("rst_tx", {31'd0, tx}, 32'd0);
      check("rst_data_out", data_out, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_pkt_done", {31'd0, pkt_done}, 32'd0);
      mon_en = 1'b1;
      @(posedge clock);
      #1;

      // Basic single-payload packet, full credit, consecutive flits.
      run_packet(8'd2, 8'd1, 1, 100, 100, -1, 0, -1, 0, -1, 1'b1);
      // Credit withheld for 4 cycles on the size flit.
      run_packet(8'd2, 8'd1, 1, 100, 100, 1, 4, -1, 0, -1, 1'b0);
      // Zero-length packet: header + size only.
      run_packet(8'd5, 8'd3, 0, 100, 100, -1, 0, -1, 0, -1, 1'b1);
      // Payload underflow: 3-cycle gap after 2nd payload flit.
      run_packet(8'd7, 8'd4, 4, 100, 100, -1, 0, 2, 3, -1, 1'b0);
      // Longer back-to-back packet at full rate.
      run_packet(8'hff, 8'hee, 6, 100, 100, -1, 0, -1, 0, -1, 1'b1);
      // Reset after the header of an 8-flit packet, then a clean packet.
      run_packet(8'd1, 8'd1, 8, 100, 100, -1, 0, -1, 0, 1, 1'b0);
      run_packet(8'd3, 8'd2, 2, 100, 100, -1, 0, -1, 0, -1, 1'b1);

      // Randomized traffic with random credit and payload gaps.
      for (int p = 0; p < 25; p++) begin
         run_packet(8'($urandom()), 8'($urandom()), $urandom_range(0, 9),
                    $urandom_range(30, 100), $urandom_range(30, 100),
                    -1, 0, -1, 0, -1, 1'b0);
      end

      repeat (3) @(posedge clock);
      check("scoreboard_empty", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
